// File: rtl/priority_encoder32_5_if.sv
// Request/selection bundle for the 32-way priority encoder.
// The design side takes the slave modport; the requester/consumer side takes master.
interface priority_encoder32_5_if;
    logic [31:0] req;
    logic        enable;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic [31:0] grant;

    modport slave (
        input  req,
        input  enable,
        input  out_ready,
        output out_idx,
        output out_valid,
        output grant
    );

    modport master (
        output req,
        output enable,
        output out_ready,
        input  out_idx,
        input  out_valid,
        input  grant
    );
endinterface

// File: rtl/priority_encoder32_5.sv
// 32-to-5 registered priority encoder with a one-entry output slot and
// optional round-robin priority rotation driven by consumer accepts.
module priority_encoder32_5 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    priority_encoder32_5_if.slave bus
);
    logic [4:0]  r_idx;
    logic        r_valid;
    logic [31:0] r_grant;
    logic [4:0]  r_ptr;

    logic        w_accept;
    logic        w_free;
    logic        w_load;
    logic [4:0]  w_eff_ptr;
    logic [4:0]  w_cand;
    logic [4:0]  w_sel;

    assign w_accept = r_valid & bus.out_ready;
    assign w_free   = ~r_valid | w_accept;
    assign w_load   = w_free & bus.enable & (|bus.req);

    // Same-cycle accept bypasses ptr so a back-to-back reload already skips the
    // index just consumed.
    assign w_eff_ptr = (ROUND_ROBIN && w_accept) ? r_idx + 5'd1 : r_ptr;

    // Scan from the farthest offset down so the nearest set bit above the
    // pointer (with wrap) is the last to write w_sel.
    always_comb begin
        w_sel  = '0;
        w_cand = '0;
        for (int i = 31; i >= 0; i--) begin
            w_cand = w_eff_ptr + 5'(i);
            if (bus.req[w_cand]) w_sel = w_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_load) begin
                r_idx   <= w_sel;
                r_valid <= 1'b1;
                r_grant <= 32'd1 << w_sel;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_grant <= '0;
            end
            if (ROUND_ROBIN && w_accept) r_ptr <= r_idx + 5'd1;
        end
    end

    assign bus.out_idx   = r_idx;
    assign bus.out_valid = r_valid;
    assign bus.grant     = r_grant;
endmodule

// File: tb/tb_priority_encoder32_5.sv
// Directed and randomized checks for priority_encoder32_5 in both priority modes.
module tb_priority_encoder32_5;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    priority_encoder32_5_if rr_if ();
    priority_encoder32_5_if fx_if ();

    priority_encoder32_5 #(.ROUND_ROBIN(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(rr_if.slave));
    priority_encoder32_5 #(.ROUND_ROBIN(1'b0)) u_fx (.clk(clk), .reset(reset), .bus(fx_if.slave));

    always #5 clk = ~clk;

    // Independent behavioural model of the round-robin instance
    logic [4:0] m_idx;
    logic       m_valid;
    logic [4:0] m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rr(input string tag, input logic v, input logic [4:0] idx, input logic [31:0] g);
        chk({tag, ".valid"}, 32'(rr_if.out_valid), 32'(v));
        chk({tag, ".idx"},   32'(rr_if.out_idx),   32'(idx));
        chk({tag, ".grant"}, rr_if.grant,          g);
    endtask

    // Advance the model by one edge using the inputs currently applied
    task automatic model_step();
        logic       acc;
        logic       ld;
        int         eff;
        int         j;
        logic [4:0] sel;
        acc = m_valid && rr_if.out_ready;
        ld  = (!m_valid || acc) && rr_if.enable && (rr_if.req != 32'd0);
        eff = acc ? (int'(m_idx) + 1) % 32 : int'(m_ptr);
        sel = '0;
        if (ld) begin
            for (int k = 0; k < 32; k++) begin
                j = (eff + k) % 32;
                if (rr_if.req[j]) begin
                    sel = 5'(j);
                    break;
                end
            end
        end
        if (acc) m_ptr = 5'((int'(m_idx) + 1) % 32);
        if (ld) begin
            m_idx   = sel;
            m_valid = 1'b1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        reset           = 1'b1;
        rr_if.req       = 32'h0000_0090;
        rr_if.enable    = 1'b1;
        rr_if.out_ready = 1'b1;
        fx_if.req       = 32'h0;
        fx_if.enable    = 1'b0;
        fx_if.out_ready = 1'b0;
        step();
        chk_rr("reset", 1'b0, 5'd0, 32'h0);
        chk("fx_reset.grant", fx_if.grant, 32'h0);

        // First load after reset scans from 0; accepts then rotate past the winner
        reset = 1'b0;
        step(); chk_rr("rr_first", 1'b1, 5'd4, 32'h0000_0010);
        step(); chk_rr("rr_second", 1'b1, 5'd7, 32'h0000_0080);
        step(); chk_rr("rr_third", 1'b1, 5'd4, 32'h0000_0010);

        rr_if.req = 32'h8000_0001;
        step(); chk_rr("wrap_31a", 1'b1, 5'd31, 32'h8000_0000);
        step(); chk_rr("wrap_0", 1'b1, 5'd0, 32'h0000_0001);
        step(); chk_rr("wrap_31b", 1'b1, 5'd31, 32'h8000_0000);

        rr_if.req = 32'h0000_0008;
        step(); chk_rr("bp_load", 1'b1, 5'd3, 32'h0000_0008);
        rr_if.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rr_if.req    = $urandom | 32'h1;
            rr_if.enable = c[0];
            step(); chk_rr("bp_hold", 1'b1, 5'd3, 32'h0000_0008);
        end
        rr_if.out_ready = 1'b1;
        rr_if.enable    = 1'b1;
        rr_if.req       = 32'h0000_0021;
        step(); chk_rr("bp_release", 1'b1, 5'd5, 32'h0000_0020);

        rr_if.enable = 1'b0;
        step(); chk_rr("en_low", 1'b0, 5'd5, 32'h0);
        rr_if.enable = 1'b1;
        rr_if.req    = 32'h0;
        step(); chk_rr("req_zero", 1'b0, 5'd5, 32'h0);
        // ptr sits at 6 after accepting 5, so a lone bit 0 is reached by wrap
        rr_if.req = 32'h0000_0001;
        step(); chk_rr("idle_load_wrap", 1'b1, 5'd0, 32'h0000_0001);

        rr_if.out_ready = 1'b0;
        reset           = 1'b1;
        step(); chk_rr("reset_busy", 1'b0, 5'd0, 32'h0);
        reset     = 1'b0;
        rr_if.req = 32'h0000_0090;
        step(); chk_rr("post_reset_ptr0", 1'b1, 5'd4, 32'h0000_0010);

        // Randomized phase against the model
        reset = 1'b1;
        step();
        reset   = 1'b0;
        m_idx   = '0;
        m_valid = 1'b0;
        m_ptr   = '0;
        for (int c = 0; c < 300; c++) begin
            rr_if.req       = (c % 7 == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            rr_if.enable    = ($urandom_range(0, 3) != 0);
            rr_if.out_ready = ($urandom_range(0, 2) != 0);
            model_step();
            step();
            chk_rr("rand", m_valid, m_idx, m_valid ? (32'd1 << m_idx) : 32'h0);
        end

        // Fixed priority: index 1 always beats index 2
        fx_if.req       = 32'h0000_0006;
        fx_if.enable    = 1'b1;
        fx_if.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("fx.valid", 32'(fx_if.out_valid), 32'd1);
            chk("fx.idx",   32'(fx_if.out_idx),   32'd1);
            chk("fx.grant", fx_if.grant,          32'h0000_0002);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
